// File: rtl/dbf_pkg.sv
// Shared definitions for the DBF receive sequencer: default widths and timing,
// FSM state encoding and small constant helpers for counter sizing.
package dbf_pkg;

  localparam int DBF_ADDR_WD     = 10;
  localparam int DBF_LINE_WD     = 8;
  localparam int DEF_TX_CYCLES   = 64;
  localparam int DEF_DEAD_CYCLES = 16;
  localparam int DEF_ZONE_LEN    = 32;
  localparam int DEF_NUM_ZONES   = 512;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_DEAD = 3'd2,
    ST_RX   = 3'd3,
    ST_NEXT = 3'd4
  } dbf_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dbf_zone_counter.sv
// Receive-window position tracker: counts samples inside a depth zone and
// advances the zone index each time a zone completes. zone_next exposes the
// value the zone register takes at the next edge so the parent can register
// its address outputs without an extra cycle of lag.
module dbf_zone_counter
  import dbf_pkg::*;
#(
  parameter int ADDR_WD   = DBF_ADDR_WD,
  parameter int ZONE_LEN  = DEF_ZONE_LEN,
  parameter int NUM_ZONES = DEF_NUM_ZONES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic               zone_last,
  output logic [ADDR_WD-1:0] zone_next
);

  localparam int SAMPLE_WD = cnt_width(ZONE_LEN);
  localparam logic [SAMPLE_WD-1:0] SAMPLE_LAST = SAMPLE_WD'(ZONE_LEN - 1);
  localparam logic [ADDR_WD-1:0]   ZONE_LAST   = ADDR_WD'(NUM_ZONES - 1);

  logic [SAMPLE_WD-1:0] sample_reg, sample_next;
  logic [ADDR_WD-1:0]   zone_reg;
  logic                 zone_wrap;

  assign zone_wrap = (sample_reg == SAMPLE_LAST);
  assign zone_last = zone_wrap && (zone_reg == ZONE_LAST);

  // Next sample/zone values; clear wins over enable, and the zone index
  // returns to 0 rather than overflowing past the last LUT entry.
  always_comb begin
    sample_next = sample_reg;
    zone_next   = zone_reg;
    if (clr) begin
      sample_next = '0;
      zone_next   = '0;
    end else if (en) begin
      if (zone_wrap) begin
        sample_next = '0;
        zone_next   = zone_last ? '0 : zone_reg + ADDR_WD'(1);
      end else begin
        sample_next = sample_reg + SAMPLE_WD'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      zone_reg   <= '0;
    end else begin
      sample_reg <= sample_next;
      zone_reg   <= zone_next;
    end
  end

endmodule

// File: rtl/dbf_rx_sequencer.sv
// Per-scan-line sequencer for the DBF receive channels. Runs TX burst, dead
// time and receive window for each line of a frame, steps the delay/apodization
// LUT address once per depth zone, and lets host LUT writes through only while
// idle. Every output comes straight from a register loaded with the value the
// FSM will be in on the following cycle.
module dbf_rx_sequencer
  import dbf_pkg::*;
#(
  parameter int ADDR_WD     = DBF_ADDR_WD,
  parameter int LINE_WD     = DBF_LINE_WD,
  parameter int TX_CYCLES   = DEF_TX_CYCLES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int ZONE_LEN    = DEF_ZONE_LEN,
  parameter int NUM_ZONES   = DEF_NUM_ZONES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_go,
  input  logic [LINE_WD-1:0] num_lines,
  input  logic               abort,
  input  logic               host_lut_we,
  input  logic [ADDR_WD-1:0] host_lut_addr,
  output logic               host_lut_ack,
  output logic               tx_en,
  output logic               start,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic [ADDR_WD-1:0] apo_addr,
  output logic [LINE_WD-1:0] line_idx,
  output logic               line_done,
  output logic               frame_done,
  output logic               busy
);

  localparam int CNT_WD = cnt_width(max_int(TX_CYCLES, DEAD_CYCLES));
  localparam logic [CNT_WD-1:0] TX_LAST   = CNT_WD'(TX_CYCLES - 1);
  localparam logic [CNT_WD-1:0] DEAD_LAST = CNT_WD'(DEAD_CYCLES - 1);

  dbf_state_t         state_reg, state_next;
  logic [CNT_WD-1:0]  cyc_reg, cyc_next;
  logic [LINE_WD-1:0] line_reg, line_next;
  logic [LINE_WD-1:0] lines_reg, lines_next;
  logic               frame_done_next;
  logic               host_grant;

  logic               zone_en, zone_clr, zone_last;
  logic [ADDR_WD-1:0] zone_next;

  logic               tx_en_reg, start_reg, busy_reg, line_done_reg, frame_done_reg;
  logic               dbf_lut_we_reg, host_lut_ack_reg;
  logic [ADDR_WD-1:0] dbf_lut_addr_reg, dbf_lut_addr_next, apo_addr_reg, apo_addr_next;

  // The zone counter runs only inside the receive window and is held at zero
  // everywhere else, so each window starts at zone 0, sample 0.
  assign zone_en  = (state_reg == ST_RX);
  assign zone_clr = (state_next != ST_RX);

  dbf_zone_counter #(
    .ADDR_WD   (ADDR_WD),
    .ZONE_LEN  (ZONE_LEN),
    .NUM_ZONES (NUM_ZONES)
  ) u_zone (
    .clk       (clk),
    .rst       (rst),
    .en        (zone_en),
    .clr       (zone_clr),
    .zone_last (zone_last),
    .zone_next (zone_next)
  );

  // Next-state logic: phase timing, line counting and host arbitration, with
  // abort overriding every other decision.
  always_comb begin
    state_next      = state_reg;
    cyc_next        = cyc_reg;
    line_next       = line_reg;
    lines_next      = lines_reg;
    frame_done_next = 1'b0;
    host_grant      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_go) begin
          state_next = ST_TX;
          cyc_next   = '0;
          line_next  = '0;
          lines_next = (num_lines == '0) ? LINE_WD'(1) : num_lines;
        end else if (host_lut_we) begin
          host_grant = 1'b1;
        end
      end
      ST_TX: begin
        if (cyc_reg == TX_LAST) begin
          state_next = ST_DEAD;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + CNT_WD'(1);
        end
      end
      ST_DEAD: begin
        if (cyc_reg == DEAD_LAST) begin
          state_next = ST_RX;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + CNT_WD'(1);
        end
      end
      ST_RX: begin
        if (zone_last) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // line_idx is only meaningful while busy, so it goes back to 0 with the FSM.
        if (line_reg == lines_reg - LINE_WD'(1)) begin
          state_next      = ST_IDLE;
          line_next       = '0;
          frame_done_next = 1'b1;
        end else begin
          state_next = ST_TX;
          cyc_next   = '0;
          line_next  = line_reg + LINE_WD'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cyc_next   = '0;
        line_next  = '0;
      end
    endcase
    if (abort) begin
      state_next      = ST_IDLE;
      cyc_next        = '0;
      line_next       = '0;
      frame_done_next = 1'b0;
      host_grant      = 1'b0;
    end
  end

  // Address muxing for the following cycle: host address on a granted write,
  // zone index inside the receive window, zero otherwise.
  always_comb begin
    dbf_lut_addr_next = '0;
    apo_addr_next     = '0;
    if (host_grant) begin
      dbf_lut_addr_next = host_lut_addr;
    end else if (state_next == ST_RX) begin
      dbf_lut_addr_next = zone_next;
      apo_addr_next     = zone_next;
    end
  end

  // FSM, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      cyc_reg          <= '0;
      line_reg         <= '0;
      lines_reg        <= '0;
      tx_en_reg        <= 1'b0;
      start_reg        <= 1'b0;
      busy_reg         <= 1'b0;
      line_done_reg    <= 1'b0;
      frame_done_reg   <= 1'b0;
      dbf_lut_we_reg   <= 1'b0;
      host_lut_ack_reg <= 1'b0;
      dbf_lut_addr_reg <= '0;
      apo_addr_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      cyc_reg          <= cyc_next;
      line_reg         <= line_next;
      lines_reg        <= lines_next;
      tx_en_reg        <= (state_next == ST_TX);
      start_reg        <= (state_next == ST_RX);
      busy_reg         <= (state_next != ST_IDLE);
      line_done_reg    <= (state_next == ST_NEXT);
      frame_done_reg   <= frame_done_next;
      dbf_lut_we_reg   <= host_grant;
      host_lut_ack_reg <= host_grant;
      dbf_lut_addr_reg <= dbf_lut_addr_next;
      apo_addr_reg     <= apo_addr_next;
    end
  end

  assign tx_en        = tx_en_reg;
  assign start        = start_reg;
  assign busy         = busy_reg;
  assign line_done    = line_done_reg;
  assign frame_done   = frame_done_reg;
  assign dbf_lut_we   = dbf_lut_we_reg;
  assign host_lut_ack = host_lut_ack_reg;
  assign dbf_lut_addr = dbf_lut_addr_reg;
  assign apo_addr     = apo_addr_reg;
  assign line_idx     = line_reg;

endmodule

// File: tb/tb_dbf_rx_sequencer.sv
// Bench for dbf_rx_sequencer with small timing parameters. The reference model
// describes a frame as a start time plus a line count; every output is derived
// arithmetically from the cycle offset into the frame.
module tb_dbf_rx_sequencer;

  localparam int AW  = 10;
  localparam int LW  = 8;
  localparam int TXC = 4;
  localparam int DC  = 2;
  localparam int ZL  = 3;
  localparam int NZ  = 4;
  localparam int P   = TXC + DC + ZL * NZ + 1;  // clocks per line incl. the NEXT clock

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_go;
  logic [LW-1:0] num_lines;
  logic          abort;
  logic          host_lut_we;
  logic [AW-1:0] host_lut_addr;
  logic          host_lut_ack;
  logic          tx_en;
  logic          start;
  logic [AW-1:0] dbf_lut_addr;
  logic          dbf_lut_we;
  logic [AW-1:0] apo_addr;
  logic [LW-1:0] line_idx;
  logic          line_done;
  logic          frame_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_active;   // a frame is in progress
  int            m_r;        // clocks since first TX clock of the frame
  int            m_lines;    // effective line count
  bit            m_fd;       // frame_done expected this clock
  bit            m_host;     // granted host write visible this clock
  logic [AW-1:0] m_haddr;

  always #5 clk = ~clk;

  dbf_rx_sequencer #(
    .ADDR_WD     (AW),
    .LINE_WD     (LW),
    .TX_CYCLES   (TXC),
    .DEAD_CYCLES (DC),
    .ZONE_LEN    (ZL),
    .NUM_ZONES   (NZ)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_go      (frame_go),
    .num_lines     (num_lines),
    .abort         (abort),
    .host_lut_we   (host_lut_we),
    .host_lut_addr (host_lut_addr),
    .host_lut_ack  (host_lut_ack),
    .tx_en         (tx_en),
    .start         (start),
    .dbf_lut_addr  (dbf_lut_addr),
    .dbf_lut_we    (dbf_lut_we),
    .apo_addr      (apo_addr),
    .line_idx      (line_idx),
    .line_done     (line_done),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int off;
    logic e_tx, e_start, e_ld, e_fd, e_busy, e_we, e_ack;
    logic [AW-1:0] e_addr, e_apo;
    logic [LW-1:0] e_line;
    e_tx = 0; e_start = 0; e_ld = 0; e_fd = 0; e_busy = 0; e_we = 0; e_ack = 0;
    e_addr = '0; e_apo = '0; e_line = '0;
    if (m_active) begin
      off     = m_r % P;
      e_line  = LW'(m_r / P);
      e_busy  = 1;
      e_tx    = (off < TXC);
      e_start = (off >= TXC + DC) && (off < TXC + DC + ZL * NZ);
      e_ld    = (off == P - 1);
      if (e_start) begin
        e_addr = AW'((off - TXC - DC) / ZL);
        e_apo  = e_addr;
      end
    end else begin
      e_fd = m_fd;
      if (m_host) begin
        e_we   = 1;
        e_ack  = 1;
        e_addr = m_haddr;
      end
    end
    chk("tx_en", tx_en, e_tx);
    chk("start", start, e_start);
    chk("dbf_lut_addr", dbf_lut_addr, e_addr);
    chk("apo_addr", apo_addr, e_apo);
    chk("dbf_lut_we", dbf_lut_we, e_we);
    chk("host_lut_ack", host_lut_ack, e_ack);
    chk("line_idx", line_idx, e_line);
    chk("line_done", line_done, e_ld);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
    chk("tx_and_start", tx_en & start, 1'b0);
  endtask

  // One clock: drive inputs on the falling edge, advance the model, check after the rising edge.
  task automatic step(input logic go, input logic [LW-1:0] nl, input logic ab,
                      input logic hwe, input logic [AW-1:0] ha);
    @(negedge clk);
    frame_go = go; num_lines = nl; abort = ab; host_lut_we = hwe; host_lut_addr = ha;
    if (ab) begin
      m_active = 0; m_fd = 0; m_host = 0;
    end else if (!m_active && go) begin
      m_active = 1; m_r = 0; m_lines = (nl == 0) ? 1 : int'(nl); m_fd = 0; m_host = 0;
    end else if (!m_active && hwe) begin
      m_host = 1; m_haddr = ha; m_fd = 0;
    end else if (m_active) begin
      m_r++; m_fd = 0; m_host = 0;
      if (m_r == m_lines * P) begin
        m_active = 0; m_fd = 1;
      end
    end else begin
      m_host = 0; m_fd = 0;
    end
    @(posedge clk);
    #1;
    frame_go = 0; abort = 0; host_lut_we = 0;
    check_outputs();
  endtask

  // Free-running clocks with optional background traffic: host requests at
  // any time, ignored frame_go pulses while busy, rare aborts.
  task automatic run(input int n, input bit noise, input bit rand_abort);
    for (int i = 0; i < n; i++) begin
      logic g, a, h;
      g = noise && m_active && ($urandom_range(0, 7) == 0);
      a = rand_abort && m_active && ($urandom_range(0, 99) == 0);
      h = noise && ($urandom_range(0, 3) == 0);
      step(g, LW'($urandom), a, h, AW'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; frame_go = 0; abort = 0; host_lut_we = 0;
    m_active = 0; m_fd = 0; m_host = 0;
    @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
  endtask

  task automatic frame(input logic [LW-1:0] nl, input bit noise);
    int len;
    step(1'b1, nl, 1'b0, 1'b0, '0);
    len = m_lines * P;
    $display("frame num_lines=%0d clocks=%0d", nl, len);
    run(len + 2, noise, 1'b0);
  endtask

  initial begin
    rst = 1; frame_go = 0; num_lines = '0; abort = 0; host_lut_we = 0; host_lut_addr = '0;
    m_active = 0; m_r = 0; m_lines = 1; m_fd = 0; m_host = 0; m_haddr = '0;
    repeat (2) @(posedge clk);
    do_reset();
    run(3, 1'b0, 1'b0);

    // Single-line, two-line-plus and zero-line frames
    frame(LW'(1), 1'b0);
    frame(LW'(3), 1'b1);
    frame(LW'(0), 1'b1);

    // Host write while idle, then the same request during RX
    step(1'b0, '0, 1'b0, 1'b1, 10'h155);
    $display("host write addr=0x155 idle");
    run(1, 1'b0, 1'b0);
    step(1'b1, LW'(1), 1'b0, 1'b0, '0);
    run(TXC + DC + 1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 10'h155);
    $display("host write addr=0x155 during rx");
    run(P, 1'b0, 1'b0);

    // Abort in zone 2, then a clean frame from line 0
    step(1'b1, LW'(2), 1'b0, 1'b0, '0);
    for (int i = 0; i < P && m_r < TXC + DC + 2 * ZL + 1; i++) run(1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    $display("abort in rx zone 2");
    run(3, 1'b0, 1'b0);
    frame(LW'(2), 1'b0);

    // frame_go with abort in IDLE, frame_go with host request, frame_go during TX
    step(1'b1, LW'(2), 1'b1, 1'b0, '0);
    run(3, 1'b0, 1'b0);
    step(1'b1, LW'(1), 1'b0, 1'b1, 10'h2AA);
    step(1'b1, LW'(5), 1'b0, 1'b0, '0);
    $display("frame_go with host request, repeated frame_go in tx");
    run(P + 2, 1'b0, 1'b0);

    // Reset in the middle of a frame
    step(1'b1, LW'(3), 1'b0, 1'b0, '0);
    run(P + 5, 1'b1, 1'b0);
    do_reset();
    $display("reset mid-frame");
    run(2, 1'b0, 1'b0);

    // Randomized frames with background traffic and occasional aborts
    for (int f = 0; f < 8; f++) begin
      logic [LW-1:0] nl;
      nl = LW'($urandom_range(0, 3));
      step(1'b1, nl, 1'b0, 1'b0, '0);
      $display("random frame num_lines=%0d", nl);
      run(m_lines * P + 3, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
